// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: res = A*B mod P, one multiplicand bit per clock,
// MSB first, with operands pre-reduced once so every partial result stays below P.
module mod_mul_serial #(
  parameter int              DW = 257,
  parameter logic [DW-1:0]   P  = DW'(256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] res,
  output logic          finish,
  output logic          busy
);

  localparam int CW = $clog2(DW);
  localparam logic [DW+1:0] P1 = (DW+2)'(P);
  localparam logic [DW+1:0] P2 = P1 << 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state_reg;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] r_reg;
  logic [CW-1:0] cnt_reg;

  logic [DW+1:0] t_sum;
  logic [DW-1:0] r_next;

  // With R < P and Br < P the step sum stays below 3P, so at most 2P has to come off.
  always_comb begin
    t_sum  = (DW+2)'({r_reg, 1'b0}) + (a_reg[cnt_reg] ? (DW+2)'(b_reg) : '0);
    r_next = DW'(t_sum);
    if (t_sum >= P2)
      r_next = DW'(t_sum - P2);
    else if (t_sum >= P1)
      r_next = DW'(t_sum - P1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      res       <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // Operands below 2P need at most one subtraction to land in [0, P).
          a_reg     <= (a_reg >= P) ? a_reg - P : a_reg;
          b_reg     <= (b_reg >= P) ? b_reg - P : b_reg;
          r_reg     <= '0;
          cnt_reg   <= CW'(DW - 1);
          state_reg <= RUN;
        end
        RUN: begin
          r_reg   <= r_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            res       <= r_next;
            finish    <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
